// File: rtl/data_memory_hs.sv
// Byte-addressed little-endian data memory with a req/ack handshake and a
// configurable access latency; misaligned accesses are flagged, not performed.
module data_memory_hs #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        misalign_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            accept_c;
    logic            access_c;
    logic            misalign_c;
    logic            mem_we_c;

    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            wr_q;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   a1_c, a2_c, a3_c;
    logic [7:0]      b0_c, b1_c, b2_c, b3_c;
    logic [31:0]     load_c;

    logic            unused_c;
    assign unused_c = ^addr_i[31:AW];

    // Next-state and counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (MemWrite_i || MemRead_i) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(LATENCY - 1);
                    accept_c  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign access_c = (state == BUSY) && (cnt == '0);

    always_comb begin
        case (size_q)
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = addr_q[0];
            default: misalign_c = (addr_q[1:0] != 2'b00);
        endcase
    end

    // Byte lane addresses; wrap is harmless since aligned accesses never cross the top
    assign a1_c = addr_q + AW'(1);
    assign a2_c = addr_q + AW'(2);
    assign a3_c = addr_q + AW'(3);
    assign b0_c = mem[addr_q];
    assign b1_c = mem[a1_c];
    assign b2_c = mem[a2_c];
    assign b3_c = mem[a3_c];

    always_comb begin
        case (size_q)
            2'b00:   load_c = {{24{~uns_q & b0_c[7]}}, b0_c};
            2'b01:   load_c = {{16{~uns_q & b1_c[7]}}, b1_c, b0_c};
            default: load_c = {b3_c, b2_c, b1_c, b0_c};
        endcase
    end

    // Reset gates the write so a store caught in flight by reset never lands
    assign mem_we_c = access_c && wr_q && !misalign_c && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            wr_q       <= 1'b0;
            data_o     <= '0;
            ack_o      <= 1'b0;
            busy_o     <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            busy_o     <= (state_nxt != IDLE);
            ack_o      <= access_c;
            misalign_o <= access_c && misalign_c;
            if (accept_c) begin
                addr_q  <= addr_i[AW-1:0];
                wdata_q <= data_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                wr_q    <= MemWrite_i;
            end
            if (access_c) begin
                if (misalign_c) begin
                    data_o <= '0;
                end else if (!wr_q) begin
                    data_o <= load_c;
                end
            end
        end
    end

    // Storage array: no reset, contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem[addr_q] <= wdata_q[7:0];
            if (size_q != 2'b00) begin
                mem[a1_c] <= wdata_q[15:8];
            end
            if (size_q[1]) begin
                mem[a2_c] <= wdata_q[23:16];
                mem[a3_c] <= wdata_q[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// Scoreboard bench for data_memory_hs: one LATENCY=4 and one LATENCY=1 instance,
// driven one at a time through a shared request bus.
module tb_data_memory_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, data;
    logic [1:0]  size;
    logic        uns, mw, mr;
    int          sel;

    logic        mw0, mr0, mw1, mr1;
    logic [31:0] dout0, dout1;
    logic        ack0, ack1, busy0, busy1, mis0, mis1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        m;
        int          s;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] hold_d [2];

    always #5 clk = ~clk;

    assign mw0 = mw & (sel == 0);
    assign mr0 = mr & (sel == 0);
    assign mw1 = mw & (sel == 1);
    assign mr1 = mr & (sel == 1);

    data_memory_hs #(.DEPTH(32), .LATENCY(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data),
        .MemWrite_i(mw0), .MemRead_i(mr0), .size_i(size), .unsigned_i(uns),
        .data_o(dout0), .ack_o(ack0), .busy_o(busy0), .misalign_o(mis0)
    );

    data_memory_hs #(.DEPTH(32), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data),
        .MemWrite_i(mw1), .MemRead_i(mr1), .size_i(size), .unsigned_i(uns),
        .data_o(dout1), .ack_o(ack1), .busy_o(busy1), .misalign_o(mis1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_ack(input int s);
        return (s == 0) ? ack0 : ack1;
    endfunction

    function automatic logic get_busy(input int s);
        return (s == 0) ? busy0 : busy1;
    endfunction

    // Monitor: every ack pops one expected response
    always @(posedge clk) begin
        #1;
        if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(ack0) | (32'(ack1) << 1), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_instance", 32'((ack0 ? 0 : 1)), 32'(e.s));
                chk("data_o", (e.s == 0) ? dout0 : dout1, e.d);
                chk("misalign_o", 32'((e.s == 0) ? mis0 : mis1), 32'(e.m));
            end
        end
    end

    task automatic do_req(input int s, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input bit u,
                          input logic [31:0] exp_d, input bit exp_m, input bit hold);
        int   lat;
        int   n;
        int   busy_n;
        exp_t e;
        lat = (s == 0) ? 4 : 1;
        @(negedge clk);
        sel = s; addr = a; data = d; size = sz; uns = u; mw = wr; mr = rd;
        if (wr && !exp_m) begin
            e.d = hold_d[s];
        end else begin
            e.d = exp_d;
            hold_d[s] = exp_d;
        end
        e.m = exp_m;
        e.s = s;
        exp_q.push_back(e);
        @(posedge clk); #1;
        n = 0;
        busy_n = 0;
        while (!get_ack(s) && n < lat + 4) begin
            if (get_busy(s)) busy_n++;
            @(posedge clk); #1;
            n++;
        end
        chk("ack_latency", 32'(n), 32'(lat));
        if (get_ack(s)) begin
            if (get_busy(s)) busy_n++;
            if (!hold) begin
                mw = 1'b0; mr = 1'b0;
            end
            @(posedge clk); #1;
            chk("ack_one_cycle", 32'(get_ack(s)), 32'h0);
            chk("busy_cycles", 32'(busy_n), 32'(lat + 1));
            chk("idle_after_done", 32'(get_busy(s)), 32'h0);
        end
        mw = 1'b0; mr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 0; addr = '0; data = '0; size = 2'b00; uns = 1'b0;
        mw = 1'b0; mr = 1'b0;
        hold_d[0] = '0; hold_d[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_o", dout0, 32'h0);
        chk("rst_ack_busy_mis", {29'h0, ack0 | ack1, busy0 | busy1, mis0 | mis1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // LATENCY=1: word store/load and byte reads
        do_req(1, 1, 0, 32'd4,  32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 0);
        do_req(1, 0, 1, 32'd4,  32'h0,        2'b10, 0, 32'hDEADBEEF, 0, 0);
        do_req(1, 0, 1, 32'd4,  32'h0,        2'b00, 1, 32'h000000EF, 0, 0);
        do_req(1, 0, 1, 32'd7,  32'h0,        2'b00, 1, 32'h000000DE, 0, 0);
        // Sign/zero extension
        do_req(1, 1, 0, 32'd9,  32'h00000080, 2'b00, 0, 32'h0,        0, 0);
        do_req(1, 0, 1, 32'd9,  32'h0,        2'b00, 0, 32'hFFFFFF80, 0, 0);
        do_req(1, 0, 1, 32'd9,  32'h0,        2'b00, 1, 32'h00000080, 0, 0);
        do_req(1, 1, 0, 32'd10, 32'h00008001, 2'b01, 0, 32'h0,        0, 0);
        do_req(1, 0, 1, 32'd10, 32'h0,        2'b01, 0, 32'hFFFF8001, 0, 0);
        do_req(1, 0, 1, 32'd10, 32'h0,        2'b01, 1, 32'h00008001, 0, 0);
        // Partial write into a word
        do_req(1, 1, 0, 32'd8,  32'h11223344, 2'b10, 0, 32'h0,        0, 0);
        do_req(1, 1, 0, 32'd9,  32'h000000AA, 2'b00, 0, 32'h0,        0, 0);
        do_req(1, 0, 1, 32'd8,  32'h0,        2'b10, 0, 32'h1122AA44, 0, 0);
        // Misalignment
        do_req(1, 1, 0, 32'd0,  32'h01020304, 2'b10, 0, 32'h0,        0, 0);
        do_req(1, 0, 1, 32'd6,  32'h0,        2'b10, 0, 32'h0,        1, 0);
        do_req(1, 1, 0, 32'd3,  32'h0000BEEF, 2'b01, 0, 32'h0,        1, 0);
        do_req(1, 0, 1, 32'd0,  32'h0,        2'b10, 0, 32'h01020304, 0, 0);

        // LATENCY=4: read+write together stores, size 11 is word, aliasing, held request
        do_req(0, 1, 1, 32'd16, 32'h55667788, 2'b10, 0, 32'h0,        0, 0);
        do_req(0, 0, 1, 32'd16, 32'h0,        2'b11, 0, 32'h55667788, 0, 0);
        do_req(0, 1, 0, 32'd36, 32'hA5A5A5A5, 2'b10, 0, 32'h0,        0, 0);
        do_req(0, 0, 1, 32'd4,  32'h0,        2'b10, 0, 32'hA5A5A5A5, 0, 1);
        do_req(0, 1, 0, 32'd12, 32'h12345678, 2'b10, 0, 32'h0,        0, 0);
        do_req(0, 0, 1, 32'd12, 32'h0,        2'b10, 0, 32'h12345678, 0, 0);

        // Reset while a store is in flight
        @(negedge clk);
        sel = 0; addr = 32'd12; data = 32'hCAFEF00D; size = 2'b10; uns = 1'b0;
        mw = 1'b1; mr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data_o", dout0, 32'h0);
        chk("async_rst_ack", 32'(ack0), 32'h0);
        chk("async_rst_busy", 32'(busy0), 32'h0);
        mw = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_d[0] = '0; hold_d[1] = '0;
        do_req(0, 0, 1, 32'd12, 32'h0,        2'b10, 0, 32'h12345678, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
